// File: rtl/calc_key_entry.sv
// Key entry stage: assembles two BCD operands and an operator from key strobes and issues them downstream.
// Latency: key effects visible one cycle after the sampled edge; out_valid holds until out_ready or 'C'.
module calc_key_entry #(
   parameter int HOLDOFF = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] a_tens,
   output logic [3:0] a_ones,
   output logic [3:0] b_tens,
   output logic [3:0] b_ones,
   output logic [1:0] op,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] entry_state,
   output logic       err
);

   // A key HOLDOFF cycles after a sampled key is sampled again; the ones in between are dropped.
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 1) ? HW'(HOLDOFF - 1) : '0;

   typedef enum logic [1:0] {
      S_A     = 2'b00,
      S_B     = 2'b01,
      S_ISSUE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      a_t_q, a_o_q, b_t_q, b_o_q;
   logic [3:0]      a_t_d, a_o_d, b_t_d, b_o_d;
   logic [1:0]      op_q, op_d;
   logic [1:0]      a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            err_q, err_d;

   logic sampled, is_digit, is_op, is_eq, is_clr, do_clear, reject, transfer;

   always_comb begin
      state_d  = state_q;
      a_t_d    = a_t_q;
      a_o_d    = a_o_q;
      b_t_d    = b_t_q;
      b_o_d    = b_o_q;
      op_d     = op_q;
      a_cnt_d  = a_cnt_q;
      b_cnt_d  = b_cnt_q;
      hold_d   = hold_q;
      do_clear = 1'b0;
      reject   = 1'b0;

      sampled  = key_valid && (hold_q == '0);
      is_digit = (key_code <= 4'd9);
      is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
      is_eq    = (key_code == 4'd14);
      is_clr   = (key_code == 4'd15);
      transfer = (state_q == S_ISSUE) && out_ready;

      if (hold_q != '0) hold_d = hold_q - 1'b1;
      if (sampled)      hold_d = HOLD_LOAD;

      case (state_q)
         S_A: if (sampled) begin
            if (is_digit) begin
               if (a_cnt_q == 2'd2) reject = 1'b1;
               else begin
                  a_t_d   = a_o_q;
                  a_o_d   = key_code;
                  a_cnt_d = a_cnt_q + 2'd1;
               end
            end else if (is_op) begin
               // code-10 modulo 4 equals code+2 modulo 4
               op_d    = key_code[1:0] + 2'd2;
               state_d = S_B;
            end else if (is_eq) reject = 1'b1;
            else if (is_clr)    do_clear = 1'b1;
         end
         S_B: if (sampled) begin
            if (is_digit) begin
               if (b_cnt_q == 2'd2) reject = 1'b1;
               else begin
                  b_t_d   = b_o_q;
                  b_o_d   = key_code;
                  b_cnt_d = b_cnt_q + 2'd1;
               end
            end else if (is_op) begin
               if (b_cnt_q == 2'd0) op_d = key_code[1:0] + 2'd2;
               else                 reject = 1'b1;
            end else if (is_eq) begin
               if (b_cnt_q != 2'd0) state_d = S_ISSUE;
               else                 reject = 1'b1;
            end else if (is_clr) do_clear = 1'b1;
         end
         S_ISSUE: begin
            if (transfer) do_clear = 1'b1;
            if (sampled) begin
               if (is_clr) do_clear = 1'b1;
               else        reject = 1'b1;
            end
         end
         default: do_clear = 1'b1;
      endcase

      if (do_clear) begin
         state_d = S_A;
         a_t_d   = '0;
         a_o_d   = '0;
         b_t_d   = '0;
         b_o_d   = '0;
         op_d    = '0;
         a_cnt_d = '0;
         b_cnt_d = '0;
      end
      err_d = reject;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_A;
         a_t_q   <= '0;
         a_o_q   <= '0;
         b_t_q   <= '0;
         b_o_q   <= '0;
         op_q    <= '0;
         a_cnt_q <= '0;
         b_cnt_q <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_t_q   <= a_t_d;
         a_o_q   <= a_o_d;
         b_t_q   <= b_t_d;
         b_o_q   <= b_o_d;
         op_q    <= op_d;
         a_cnt_q <= a_cnt_d;
         b_cnt_q <= b_cnt_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   assign a_tens      = a_t_q;
   assign a_ones      = a_o_q;
   assign b_tens      = b_t_q;
   assign b_ones      = b_o_q;
   assign op          = op_q;
   assign out_valid   = (state_q == S_ISSUE);
   assign entry_state = state_q;
   assign err         = err_q;

endmodule
